e_mdu_ctrl: RTL and testbench
=============================

# e_mdu_ctrl

Multiply/divide scheduler for the execute stage of the pipelined MIPS CPU. Accepts one MDU instruction at a time from E and sequences a fixed-latency multiply (5 cycles) or divide (10 cycles). Commits results to the architectural HI/LO registers and exposes a busy indication so the hazard unit can stall later mult/div/mfhi/mflo/mthi/mtlo instructions in D.

## Interface

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- op_valid  input  1  E holds an MDU instruction this cycle; one-cycle pulse per instruction
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- rs_val  input  32  forwarded GPR[rs]
- rt_val  input  32  forwarded GPR[rt]
- flush  input  1  abort in-flight operation; present only with MDU_FLUSH_EN
- busy  output  1  registered; operation in flight
- md_hazard  output  1  combinational: busy | (op_valid & op in 1..4); used by hazard unit
- hi  output  32  registered HI
- lo  output  32  registered LO

## Operation

- States: IDLE, RUN. Down-counter cnt (4 bits minimum, sized for max(MULT_CYCLES, DIV_CYCLES)).
- IDLE, op_valid & op∈{1..4}: latch result into hi_tmp/lo_tmp, load cnt with MULT_CYCLES or DIV_CYCLES, go to RUN, busy←1.
- Result computation:
  - mult: signed 32×32→64, {hi_tmp,lo_tmp}=product.
  - multu: unsigned 32×32→64, {hi_tmp,lo_tmp}=product.
  - div: lo_tmp=signed quotient truncated toward zero; hi_tmp=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - rs is the dividend.
- Signed div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (div/divu, rt_val=0): full DIV_CYCLES busy period, HI/LO unchanged at commit.
- RUN: cnt decrements each cycle. When cnt==1: hi←hi_tmp, lo←lo_tmp, busy←0, go to IDLE (same edge).
- mthi/mtlo, op_valid in IDLE: hi←rs_val or lo←rs_val at the next edge; no busy.
- op_valid while busy (any op): ignored, no state change. The hazard unit guarantees this never occurs; the bench checks that the operation is ignored.
- reset: busy=0, hi=0, lo=0, cnt=0, hi_tmp=lo_tmp=0, state IDLE. Takes priority over everything; aborts RUN with no commit.

## Timing

- Start accepted at edge E0: busy=1 during cycles E0+1 … E0+N (N = MULT_CYCLES or DIV_CYCLES).
- hi/lo show the new value from the cycle after edge E0+N, which is the same edge where busy falls.
- Back-to-back: a new op_valid in the first cycle with busy=0 is accepted.
- mthi/mtlo: 1-cycle latency; the new value is visible in the cycle after the accepting edge.
- md_hazard is asserted in the start cycle itself, so a dependent instruction in D stalls with zero gap.
- hi/lo are stable throughout RUN; mfhi/mflo is stalled anyway via md_hazard.

## Configuration

- MDU_FLUSH_EN defined: flush port exists.
  - flush=1 in RUN: next edge → IDLE, busy=0, no commit.
  - flush=1 together with op_valid in IDLE: op dropped, including mthi/mtlo.
  - reset has priority over flush.
- MDU_FLUSH_EN undefined: no flush port; an operation always runs to commit unless reset is asserted.

## Test plan

- mult rs=0xFFFFFFFE (−2), rt=3 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div rs=0xFFFFFFF9 (−7), rt=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- divu rs=5, rt=0 after mthi 0x1234 / mtlo 0x5678 → busy 10 cycles; HI=0x1234, LO=0x5678 unchanged. mthi/mtlo each visible 1 cycle after accept with busy=0.
- Start div, assert reset in 4th busy cycle → next cycle busy=0, HI=LO=0. Also: op_valid mult during busy is ignored, and the original result commits on schedule.
- With MDU_FLUSH_EN: start mult, flush in 2nd busy cycle → busy=0 next cycle, HI/LO hold prior values. Back-to-back mult accepted on the first non-busy cycle commits 5 cycles later.

Source files
------------

// File: rtl/e_mdu_ctrl.sv
// rtl/e_mdu_ctrl.sv - fixed-latency multiply/divide scheduler with architectural HI/LO
// Optional abort input enabled by defining MDU_FLUSH_EN.
module e_mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
`ifdef MDU_FLUSH_EN
   input  logic        flush,
`endif
   output logic        busy,
   output logic        md_hazard,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;

   typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

   state_t      state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [31:0] hi_tmp, lo_tmp, hi_tmp_nx, lo_tmp_nx;
   logic [31:0] hi_nx, lo_nx;
   logic        kill;
   logic        is_md, is_mult;

`ifdef MDU_FLUSH_EN
   assign kill = flush;
`else
   assign kill = 1'b0;
`endif

   assign is_md     = (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
   assign is_mult   = (op == 3'd1) || (op == 3'd2);
   assign busy      = (state == S_RUN);
   assign md_hazard = busy | (op_valid & is_md);

   // Products and quotients are formed in the start cycle and parked in hi_tmp/lo_tmp.
   logic [63:0] prod_s, prod_u;
   logic [31:0] a_abs, b_abs, uq, ur, sq, sr, dq, dr;
   logic [31:0] res_hi, res_lo;

   assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
   assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

   // Signed divide on magnitudes: keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
   assign a_abs = (op == 3'd3 && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
   assign b_abs = (op == 3'd3 && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
   assign uq    = (b_abs == 32'd0) ? 32'd0 : a_abs / b_abs;
   assign ur    = (b_abs == 32'd0) ? 32'd0 : a_abs % b_abs;
   assign sq    = (rs_val[31] ^ rt_val[31]) ? (~uq + 32'd1) : uq;
   assign sr    = rs_val[31] ? (~ur + 32'd1) : ur;
   assign dq    = (op == 3'd3) ? sq : uq;
   assign dr    = (op == 3'd3) ? sr : ur;

   always_comb begin
      res_hi = hi;
      res_lo = lo;
      case (op)
         3'd1: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         3'd2: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         3'd3, 3'd4: begin
            // Divide by zero commits the current HI/LO back, i.e. leaves them unchanged.
            if (rt_val != 32'd0) begin
               res_hi = dr;
               res_lo = dq;
            end
         end
         default: begin
            res_hi = hi;
            res_lo = lo;
         end
      endcase
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      hi_nx     = hi;
      lo_nx     = lo;
      hi_tmp_nx = hi_tmp;
      lo_tmp_nx = lo_tmp;
      case (state)
         S_IDLE: begin
            if (op_valid && !kill) begin
               if (is_md) begin
                  state_nx  = S_RUN;
                  cnt_nx    = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                  hi_tmp_nx = res_hi;
                  lo_tmp_nx = res_lo;
               end else if (op == 3'd5) begin
                  hi_nx = rs_val;
               end else if (op == 3'd6) begin
                  lo_nx = rs_val;
               end
            end
         end
         S_RUN: begin
            if (kill) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end else if (cnt == CW'(1)) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
               hi_nx    = hi_tmp;
               lo_nx    = lo_tmp;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         hi     <= 32'd0;
         lo     <= 32'd0;
         hi_tmp <= 32'd0;
         lo_tmp <= 32'd0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         hi     <= hi_nx;
         lo     <= lo_nx;
         hi_tmp <= hi_tmp_nx;
         lo_tmp <= lo_tmp_nx;
      end
   end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// tb/tb_e_mdu_ctrl.sv - directed self-checking bench for e_mdu_ctrl
module tb_e_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] rs_val, rt_val;
   logic        busy, md_hazard;
   logic [31:0] hi, lo;
`ifdef MDU_FLUSH_EN
   logic        flush;
`endif

   int total = 0;
   int bad   = 0;
   int n;

   e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk),
      .reset(reset),
      .op_valid(op_valid),
      .op(op),
      .rs_val(rs_val),
      .rt_val(rt_val),
`ifdef MDU_FLUSH_EN
      .flush(flush),
`endif
      .busy(busy),
      .md_hazard(md_hazard),
      .hi(hi),
      .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one op for a single edge; checks md_hazard in the start cycle.
   task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic haz);
      op_valid = 1'b1;
      op       = o;
      rs_val   = a;
      rt_val   = b;
      #1;
      chk({tag, "_hazard"}, {31'd0, md_hazard}, {31'd0, haz});
      step();
      op_valid = 1'b0;
      op       = 3'd0;
   endtask

   // Counts the busy cycles remaining, bounded so a stuck busy cannot hang the run.
   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 40) begin
         cycles++;
         step();
      end
   endtask

   initial begin
      reset    = 1'b1;
      op_valid = 1'b0;
      op       = 3'd0;
      rs_val   = 32'd0;
      rt_val   = 32'd0;
`ifdef MDU_FLUSH_EN
      flush    = 1'b0;
`endif
      step();
      step();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_hazard", {31'd0, md_hazard}, 32'd0);
      reset = 1'b0;
      step();

      issue("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
      chk("mult_busy_hi", hi, 32'd0);
      wait_idle(n);
      chk("mult_cycles", n, 32'd5);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFA);

      issue("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      wait_idle(n);
      chk("multu_cycles", n, 32'd5);
      chk("multu_hi", hi, 32'hFFFF_FFFE);
      chk("multu_lo", lo, 32'h0000_0001);

      issue("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_idle(n);
      chk("div_cycles", n, 32'd10);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);

      issue("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_idle(n);
      chk("divovf_cycles", n, 32'd10);
      chk("divovf_lo", lo, 32'h8000_0000);
      chk("divovf_hi", hi, 32'h0000_0000);

      issue("mthi", 3'd5, 32'h0000_1234, 32'd0, 1'b0);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      chk("mthi_hi", hi, 32'h0000_1234);
      issue("mtlo", 3'd6, 32'h0000_5678, 32'd0, 1'b0);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);
      chk("mtlo_lo", lo, 32'h0000_5678);
      chk("mtlo_hi", hi, 32'h0000_1234);

      issue("divu0", 3'd4, 32'd5, 32'd0, 1'b1);
      wait_idle(n);
      chk("divu0_cycles", n, 32'd10);
      chk("divu0_hi", hi, 32'h0000_1234);
      chk("divu0_lo", lo, 32'h0000_5678);

      // Ops offered while busy must be ignored; the original mult still commits on time.
      issue("mult_ign", 3'd1, 32'd6, 32'd7, 1'b1);
      op_valid = 1'b1; op = 3'd1; rs_val = 32'd100; rt_val = 32'd100;
      step();
      chk("ign_mult_hi", hi, 32'h0000_1234);
      op = 3'd5; rs_val = 32'h0000_DEAD;
      step();
      op_valid = 1'b0; op = 3'd0;
      chk("ign_mthi_hi", hi, 32'h0000_1234);
      chk("ign_busy", {31'd0, busy}, 32'd1);
      wait_idle(n);
      chk("ign_cycles", n, 32'd3);
      chk("ign_hi", hi, 32'h0000_0000);
      chk("ign_lo", lo, 32'h0000_002A);

      issue("b2b", 3'd1, 32'd2, 32'd3, 1'b1);
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      wait_idle(n);
      chk("b2b_cycles", n, 32'd5);
      chk("b2b_lo", lo, 32'd6);

      issue("divrst", 3'd3, 32'd100, 32'd7, 1'b1);
      step();
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_run_busy", {31'd0, busy}, 32'd0);
      chk("rst_run_hi", hi, 32'd0);
      chk("rst_run_lo", lo, 32'd0);
      for (int i = 0; i < 12; i++) step();
      chk("rst_late_lo", lo, 32'd0);
      chk("rst_late_busy", {31'd0, busy}, 32'd0);

`ifdef MDU_FLUSH_EN
      issue("fl_mthi", 3'd5, 32'h11, 32'd0, 1'b0);
      issue("fl_mtlo", 3'd6, 32'h22, 32'd0, 1'b0);
      issue("fl_mult", 3'd1, 32'd3, 32'd3, 1'b1);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 6; i++) step();
      chk("flush_hi", hi, 32'h11);
      chk("flush_lo", lo, 32'h22);
      flush = 1'b1;
      issue("fl_drop", 3'd5, 32'h99, 32'd0, 1'b0);
      flush = 1'b0;
      chk("flush_drop_hi", hi, 32'h11);
      chk("flush_drop_busy", {31'd0, busy}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
